// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye SDRAM read arbiter.
//   arb_state_t    : arbiter FSM states
//   SDRAM_AW/DW    : SDRAM word-address and data widths
//   *_OFFSET_DEF   : default SDRAM word bases of the CPU and object ROMs
package jtpopeye_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } arb_state_t;

  localparam int SDRAM_AW = 22;
  localparam int SDRAM_DW = 32;

  localparam logic [SDRAM_AW-1:0] CPU_OFFSET_DEF = 22'h00_0000;
  localparam logic [SDRAM_AW-1:0] OBJ_OFFSET_DEF = 22'h00_2000;

endpackage

// File: rtl/jtpopeye_sdram_slot.sv
// One requester's landing slot: the last word read from SDRAM, the address
// it was read for, and a valid flag. ok is combinational so a requester sees
// its data the cycle after the write without an extra register stage.
//   clk, rst_n       : clock, synchronous active-low reset
//   we               : store we_addr/we_data and mark the slot valid
//   cs, addr         : requester enable and its current lookup address
//   data             : stored word, held until the next write
//   ok               : cs high, slot valid and stored address == addr
module jtpopeye_sdram_slot
  import jtpopeye_pkg::*;
#(
  parameter int AW     = 13,
  parameter int DATA_W = SDRAM_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     we_addr,
  input  logic [DATA_W-1:0] we_data,
  input  logic              cs,
  input  logic [AW-1:0]     addr,
  output logic [DATA_W-1:0] data,
  output logic              ok
);

  logic          valid;
  logic [AW-1:0] sto_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      sto_addr <= '0;
      data     <= '0;
    end else if (we) begin
      valid    <= 1'b1;
      sto_addr <= we_addr;
      data     <= we_data;
    end
  end

  assign ok = cs & valid & (sto_addr == addr);

endmodule

// File: rtl/jtpopeye_sdram_arb.sv
// SDRAM read arbiter between the main CPU ROM and the object ROM fetcher.
// One read is in flight at a time; the object fetcher normally wins, but
// after MAX_OBJ back-to-back object grants with the CPU waiting the CPU is
// served.
//   clk, rst_n              : clock, synchronous active-low reset
//   cpu_cs/cpu_addr         : CPU byte-address request (level)
//   cpu_data/cpu_ok         : selected byte lane and its validity
//   obj_cs/obj_addr         : object word-address request (level)
//   objrom_data/obj_ok      : fetched object word and its validity
//   sdram_req/addr/ack      : request handshake to the SDRAM controller
//   sdram_rdy/sdram_dout    : one-cycle read-data strobe and data
// Build option: define JTPOPEYE_CPU_CACHE_EN to make the CPU slot a one-word
// cache (hits on any byte of the stored word); otherwise every new CPU byte
// address triggers its own SDRAM read.
module jtpopeye_sdram_arb
  import jtpopeye_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] CPU_OFFSET = CPU_OFFSET_DEF,
  parameter logic [SDRAM_AW-1:0] OBJ_OFFSET = OBJ_OFFSET_DEF,
  parameter int                  MAX_OBJ    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_cs,
  input  logic [14:0]         cpu_addr,
  output logic [7:0]          cpu_data,
  output logic                cpu_ok,
  input  logic                obj_cs,
  input  logic [12:0]         obj_addr,
  output logic [31:0]         objrom_data,
  output logic                obj_ok,
  output logic                sdram_req,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  input  logic [31:0]         sdram_dout
);

  localparam logic [7:0] MAX_C = 8'(MAX_OBJ);

`ifdef JTPOPEYE_CPU_CACHE_EN
  localparam int CPU_KW = 13;
  logic [CPU_KW-1:0] cpu_key;
  assign cpu_key = cpu_addr[14:2];
`else
  localparam int CPU_KW = 15;
  logic [CPU_KW-1:0] cpu_key;
  assign cpu_key = cpu_addr;
`endif

  arb_state_t          state, state_nxt;
  logic                req_nxt;
  logic [SDRAM_AW-1:0] addr_nxt;
  logic                win_cpu, win_cpu_nxt;
  logic [CPU_KW-1:0]   cap_cpu, cap_cpu_nxt;
  logic [12:0]         cap_obj, cap_obj_nxt;
  logic [7:0]          obj_cnt, obj_cnt_nxt;
  logic                grant, done;
  logic                cpu_pend, obj_pend, cpu_wins;
  logic [31:0]         cpu_word;

  assign cpu_pend = cpu_cs & ~cpu_ok;
  assign obj_pend = obj_cs & ~obj_ok;
  // The CPU only overtakes once the object streak has reached the limit.
  assign cpu_wins = cpu_pend & (~obj_pend | (obj_cnt >= MAX_C));

  always_comb begin
    state_nxt   = state;
    req_nxt     = sdram_req;
    addr_nxt    = sdram_addr;
    win_cpu_nxt = win_cpu;
    cap_cpu_nxt = cap_cpu;
    cap_obj_nxt = cap_obj;
    grant       = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_pend | obj_pend) begin
          grant       = 1'b1;
          win_cpu_nxt = cpu_wins;
          req_nxt     = 1'b1;
          state_nxt   = WAIT_ACK;
          if (cpu_wins) begin
            cap_cpu_nxt = cpu_key;
            addr_nxt    = CPU_OFFSET + SDRAM_AW'(cpu_addr[14:2]);
          end else begin
            cap_obj_nxt = obj_addr;
            addr_nxt    = OBJ_OFFSET + SDRAM_AW'(obj_addr);
          end
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          req_nxt = 1'b0;
          // Data may come back on the acknowledge cycle itself.
          if (sdram_rdy) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (sdram_rdy) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Object streak only counts grants made while the CPU is kept waiting.
    obj_cnt_nxt = obj_cnt;
    if (!cpu_pend || (grant && cpu_wins)) begin
      obj_cnt_nxt = 8'd0;
    end else if (grant && obj_cnt < MAX_C) begin
      obj_cnt_nxt = obj_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      win_cpu    <= 1'b0;
      cap_cpu    <= '0;
      cap_obj    <= '0;
      obj_cnt    <= 8'd0;
    end else begin
      state      <= state_nxt;
      sdram_req  <= req_nxt;
      sdram_addr <= addr_nxt;
      win_cpu    <= win_cpu_nxt;
      cap_cpu    <= cap_cpu_nxt;
      cap_obj    <= cap_obj_nxt;
      obj_cnt    <= obj_cnt_nxt;
    end
  end

  jtpopeye_sdram_slot #(.AW(CPU_KW)) u_cpu_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (done & win_cpu),
    .we_addr (cap_cpu),
    .we_data (sdram_dout),
    .cs      (cpu_cs),
    .addr    (cpu_key),
    .data    (cpu_word),
    .ok      (cpu_ok)
  );

  jtpopeye_sdram_slot #(.AW(13)) u_obj_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (done & ~win_cpu),
    .we_addr (cap_obj),
    .we_data (sdram_dout),
    .cs      (obj_cs),
    .addr    (obj_addr),
    .data    (objrom_data),
    .ok      (obj_ok)
  );

  // Little-endian lane select on the live address, so cached hits pick the
  // right byte without another read.
  assign cpu_data = cpu_word[{cpu_addr[1:0], 3'b000} +: 8];

endmodule

// File: tb/tb_jtpopeye_sdram_arb.sv
module tb_jtpopeye_sdram_arb;

  localparam int MAXO = 2;
`ifdef JTPOPEYE_CPU_CACHE_EN
  localparam int EXP_READS = 1;
`else
  localparam int EXP_READS = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_cs = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [7:0]  cpu_data;
  logic        cpu_ok;
  logic        obj_cs = 1'b0;
  logic [12:0] obj_addr = '0;
  logic [31:0] objrom_data;
  logic        obj_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack = 1'b0;
  logic        sdram_rdy = 1'b0;
  logic [31:0] sdram_dout = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jtpopeye_sdram_arb #(
    .CPU_OFFSET (22'h00_0000),
    .OBJ_OFFSET (22'h00_2000),
    .MAX_OBJ    (MAXO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_cs      (cpu_cs),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_ok      (cpu_ok),
    .obj_cs      (obj_cs),
    .obj_addr    (obj_addr),
    .objrom_data (objrom_data),
    .obj_ok      (obj_ok),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .sdram_rdy   (sdram_rdy),
    .sdram_dout  (sdram_dout)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] s);
    return 8'(w >> (8 * int'(s)));
  endfunction

  // Key under which the CPU slot is looked up: word in cache mode, byte otherwise.
  function automatic logic [14:0] ckey(input logic [14:0] a);
`ifdef JTPOPEYE_CPU_CACHE_EN
    return {2'b00, a[14:2]};
`else
    return a;
`endif
  endfunction

  task automatic wait_req(input int lim, output bit seen);
    int n = 0;
    while (sdram_req !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    seen = (sdram_req === 1'b1);
    if (!seen) chk("req_timeout", 32'(sdram_req), 1);
  endtask

  // Act as the SDRAM controller for one access: ack after ack_d cycles,
  // rdy rdy_d cycles after ack (0 = same cycle). Returns one cycle after rdy.
  task automatic serve(input int ack_d, input int rdy_d, input logic [31:0] dout,
                       output logic [21:0] sa);
    bit seen;
    wait_req(20, seen);
    sa = sdram_addr;
    if (!seen) return;
    for (int i = 0; i < ack_d; i++) begin
      step();
      chk("req_held", 32'(sdram_req), 1);
      chk("addr_held", 32'(sdram_addr), 32'(sa));
    end
    sdram_ack = 1'b1;
    if (rdy_d == 0) begin
      chk("ok_before_rdy", 32'({cpu_ok, obj_ok}), 0);
      sdram_rdy  = 1'b1;
      sdram_dout = dout;
    end
    step();
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    if (rdy_d > 0) begin
      chk("req_drop", 32'(sdram_req), 0);
      for (int i = 1; i < rdy_d; i++) step();
      chk("ok_before_rdy", 32'({cpu_ok, obj_ok}), 0);
      sdram_rdy  = 1'b1;
      sdram_dout = dout;
      step();
      sdram_rdy = 1'b0;
    end
  endtask

  typedef struct {
    bit          is_cpu;
    logic [14:0] addr;
    int          ack_d;
    int          rdy_d;
    logic [31:0] dout;
    logic [21:0] exp_sa;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  // Reference model state for the random phase.
  bit          busy, acked, m_win_cpu, cp, op, grant, gcpu;
  logic [21:0] m_sa;
  logic [14:0] m_cap;
  bit          m_cpu_v, m_obj_v;
  logic [14:0] m_cpu_key;
  logic [12:0] m_obj_key;
  logic [31:0] m_cpu_d, m_obj_d;
  int          streak;
  logic        exp_cok, exp_ook;

  initial begin
    logic [21:0] sa;
    bit          seen;
    bit          exp_cpu[6];
    int          reads;

    vecs[0] = '{0, 15'h0010, 2, 3, 32'hDEADBEEF, 22'h002010, 32'hDEADBEEF};
    vecs[1] = '{0, 15'h1FFF, 1, 1, 32'h12345678, 22'h003FFF, 32'h12345678};
    vecs[2] = '{0, 15'h0000, 0, 0, 32'h13579BDF, 22'h002000, 32'h13579BDF};
    vecs[3] = '{1, 15'h0104, 1, 2, 32'hA0B1C2D3, 22'h000041, 32'h000000D3};
    vecs[4] = '{1, 15'h7FFF, 3, 1, 32'h55667788, 22'h001FFF, 32'h00000055};
    vecs[5] = '{1, 15'h0002, 0, 1, 32'h0BADF00D, 22'h000000, 32'h000000AD};
    vecs[6] = '{0, 15'h0ABC, 0, 4, 32'hCAFEF00D, 22'h002ABC, 32'hCAFEF00D};
    exp_cpu = '{0, 0, 1, 0, 0, 1};

    // Reset with both requesters asserted
    cpu_cs = 1'b1; obj_cs = 1'b1; cpu_addr = 15'h0123; obj_addr = 13'h0042;
    step(); step();
    chk("rst_req", 32'(sdram_req), 0);
    chk("rst_addr", 32'(sdram_addr), 0);
    chk("rst_cpu_ok", 32'(cpu_ok), 0);
    chk("rst_obj_ok", 32'(obj_ok), 0);
    chk("rst_cpu_data", 32'(cpu_data), 0);
    chk("rst_obj_data", objrom_data, 0);
    cpu_cs = 1'b0; obj_cs = 1'b0;
    rst_n = 1'b1;
    step();

    // Single-requester vectors
    for (int i = 0; i < 7; i++) begin
      cpu_cs = vecs[i].is_cpu;
      obj_cs = !vecs[i].is_cpu;
      if (vecs[i].is_cpu) cpu_addr = vecs[i].addr;
      else obj_addr = vecs[i].addr[12:0];
      serve(vecs[i].ack_d, vecs[i].rdy_d, vecs[i].dout, sa);
      chk($sformatf("vec%0d_sa", i), 32'(sa), 32'(vecs[i].exp_sa));
      if (vecs[i].is_cpu) begin
        chk($sformatf("vec%0d_ok", i), 32'(cpu_ok), 1);
        chk($sformatf("vec%0d_data", i), 32'(cpu_data), vecs[i].exp_data);
      end else begin
        chk($sformatf("vec%0d_ok", i), 32'(obj_ok), 1);
        chk($sformatf("vec%0d_data", i), objrom_data, vecs[i].exp_data);
      end
      cpu_cs = 1'b0; obj_cs = 1'b0;
      step();
    end

    // ack and rdy together: back in IDLE so the next grant follows at once
    obj_cs = 1'b1; obj_addr = 13'h0007;
    serve(0, 0, 32'h77770007, sa);
    chk("ackrdy_ok", 32'(obj_ok), 1);
    obj_addr = 13'h0008;
    step();
    chk("ackrdy_next_req", 32'(sdram_req), 1);
    chk("ackrdy_next_addr", 32'(sdram_addr), 32'h002008);
    serve(1, 1, 32'h77770008, sa);
    obj_cs = 1'b0;
    step();

    // Contention: both pending every cycle
    cpu_addr = 15'h0200; obj_addr = 13'h0100;
    cpu_cs = 1'b1; obj_cs = 1'b1;
    for (int k = 0; k < 6; k++) begin
      serve(1, 1, 32'h1000 + k, sa);
      chk($sformatf("grant%0d_is_cpu", k), 32'(sa < 22'h002000), 32'(exp_cpu[k]));
      if (sa < 22'h002000) cpu_addr = cpu_addr + 15'd4;
      else obj_addr = obj_addr + 13'd1;
    end
    cpu_cs = 1'b0; obj_cs = 1'b0;
    step();

    // Same-word CPU addresses
    reads = 0;
    cpu_cs = 1'b1; cpu_addr = 15'h0100;
    serve(1, 1, 32'hA1B2C3D4, sa);
    reads++;
    chk("cache_sa0", 32'(sa), 32'h000040);
    chk("cache_ok0", 32'(cpu_ok), 1);
    chk("cache_lane0", 32'(cpu_data), 32'h000000D4);
    cpu_addr = 15'h0103;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (sdram_req) break;
      step();
    end
    if (sdram_req) begin
      serve(1, 1, 32'hA1B2C3D4, sa);
      reads++;
      chk("cache_sa1", 32'(sa), 32'h000040);
    end
    chk("cache_reads", reads, EXP_READS);
    chk("cache_ok1", 32'(cpu_ok), 1);
    chk("cache_lane3", 32'(cpu_data), 32'h000000A1);
    cpu_cs = 1'b0;
    step();

    // Object address change while waiting for rdy
    obj_cs = 1'b1; obj_addr = 13'h0005;
    wait_req(20, seen);
    chk("chg_sa0", 32'(sdram_addr), 32'h002005);
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    step();
    obj_addr = 13'h0006;
    step();
    sdram_rdy = 1'b1; sdram_dout = 32'h5555AAAA;
    step();
    sdram_rdy = 1'b0;
    chk("chg_ok_low", 32'(obj_ok), 0);
    chk("chg_data_stored", objrom_data, 32'h5555AAAA);
    step();
    chk("chg_req2", 32'(sdram_req), 1);
    chk("chg_sa2", 32'(sdram_addr), 32'h002006);
    serve(1, 1, 32'h66666666, sa);
    chk("chg_ok2", 32'(obj_ok), 1);
    chk("chg_data2", objrom_data, 32'h66666666);
    obj_cs = 1'b0;
    step();

    // cs dropped mid-flight: access still stored
    obj_cs = 1'b1; obj_addr = 13'h0020;
    wait_req(20, seen);
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    obj_cs = 1'b0;
    step();
    sdram_rdy = 1'b1; sdram_dout = 32'h0F0F1234;
    step();
    sdram_rdy = 1'b0;
    chk("csdrop_ok_low", 32'(obj_ok), 0);
    step();
    chk("csdrop_no_req", 32'(sdram_req), 0);
    obj_cs = 1'b1;
    #1;
    chk("csdrop_ok_hit", 32'(obj_ok), 1);
    chk("csdrop_data", objrom_data, 32'h0F0F1234);
    step();
    chk("csdrop_hit_no_req", 32'(sdram_req), 0);
    obj_cs = 1'b0;
    step();

    // Reset during WAIT_RDY, stray rdy afterwards
    obj_cs = 1'b1; obj_addr = 13'h0030;
    wait_req(20, seen);
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    step();
    rst_n = 1'b0; obj_cs = 1'b0;
    step();
    chk("midrst_req", 32'(sdram_req), 0);
    chk("midrst_obj_ok", 32'(obj_ok), 0);
    chk("midrst_cpu_ok", 32'(cpu_ok), 0);
    chk("midrst_data", objrom_data, 0);
    rst_n = 1'b1;
    step();
    sdram_rdy = 1'b1; sdram_dout = 32'h77777777;
    step();
    sdram_rdy = 1'b0;
    chk("midrst_req_after_rdy", 32'(sdram_req), 0);
    chk("midrst_data_after_rdy", objrom_data, 0);
    obj_cs = 1'b1;
    #1;
    chk("midrst_no_slot_update", 32'(obj_ok), 0);
    step();
    chk("midrst_rereq", 32'(sdram_req), 1);
    chk("midrst_rereq_sa", 32'(sdram_addr), 32'h002030);
    serve(1, 1, 32'h30303030, sa);
    obj_cs = 1'b0;
    step();

    // Random phase against the reference model
    rst_n = 1'b0; cpu_cs = 1'b0; obj_cs = 1'b0;
    step(); step();
    rst_n = 1'b1;
    busy = 0; acked = 0; m_win_cpu = 0; m_sa = '0; m_cap = '0;
    m_cpu_v = 0; m_obj_v = 0; m_cpu_key = '0; m_obj_key = '0;
    m_cpu_d = '0; m_obj_d = '0; streak = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      exp_cok = cpu_cs && m_cpu_v && (m_cpu_key == ckey(cpu_addr));
      exp_ook = obj_cs && m_obj_v && (m_obj_key == obj_addr);
      chk("rnd_cpu_ok", 32'(cpu_ok), 32'(exp_cok));
      chk("rnd_obj_ok", 32'(obj_ok), 32'(exp_ook));
      chk("rnd_cpu_data", 32'(cpu_data), 32'(lane(m_cpu_d, cpu_addr[1:0])));
      chk("rnd_obj_data", objrom_data, m_obj_d);
      chk("rnd_req", 32'(sdram_req), 32'(busy && !acked));
      if (busy && !acked) chk("rnd_sa", 32'(sdram_addr), 32'(m_sa));

      if ($urandom_range(0, 4) == 0) cpu_cs = ~cpu_cs;
      if ($urandom_range(0, 4) == 0) obj_cs = ~obj_cs;
      if ($urandom_range(0, 3) == 0) cpu_addr = 15'h0100 + 15'($urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) obj_addr = 13'($urandom_range(0, 3));
      sdram_ack = 1'b0; sdram_rdy = 1'b0;
      sdram_dout = $urandom();
      if (busy && !acked && $urandom_range(0, 2) == 0) begin
        sdram_ack = 1'b1;
        if ($urandom_range(0, 3) == 0) sdram_rdy = 1'b1;
      end else if (busy && acked && $urandom_range(0, 2) == 0) begin
        sdram_rdy = 1'b1;
      end

      cp    = cpu_cs && !(m_cpu_v && m_cpu_key == ckey(cpu_addr));
      op    = obj_cs && !(m_obj_v && m_obj_key == obj_addr);
      grant = !busy && (cp || op);
      gcpu  = cp && (!op || streak >= MAXO);

      step();

      if (!cp) streak = 0;
      else if (grant && gcpu) streak = 0;
      else if (grant && streak < MAXO) streak++;
      if (grant) begin
        busy = 1; acked = 0; m_win_cpu = gcpu;
        if (gcpu) begin
          m_cap = ckey(cpu_addr);
          m_sa  = 22'(cpu_addr >> 2);
        end else begin
          m_cap = 15'(obj_addr);
          m_sa  = 22'h002000 + 22'(obj_addr);
        end
      end else begin
        if (sdram_ack) acked = 1;
        if (sdram_rdy) begin
          busy = 0;
          if (m_win_cpu) begin
            m_cpu_v = 1; m_cpu_key = m_cap; m_cpu_d = sdram_dout;
          end else begin
            m_obj_v = 1; m_obj_key = m_cap[12:0]; m_obj_d = sdram_dout;
          end
        end
      end
    end
    sdram_ack = 1'b0; sdram_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtpopeye_sdram_arb.md
JTPOPEYE_SDRAM_ARB -- requirements
Module: jtpopeye_sdram_arb

Interface
REQ-001 Parameter CPU_OFFSET, default 22'h00_0000: SDRAM word base of the main CPU ROM.
REQ-002 Parameter OBJ_OFFSET, default 22'h00_2000: SDRAM word base of the object ROM.
REQ-003 Parameter MAX_OBJ, default 2: maximum consecutive object grants while a CPU request waits.
REQ-004 Ports (name, direction, width, meaning), one per line:
  clk  in  1  system clock, single clock domain;
  rst_n  in  1  reset, synchronous, active-low;
  cpu_cs  in  1  CPU ROM access request (level);
  cpu_addr  in  15  CPU byte address;
  cpu_data  out  8  byte selected by cpu_addr[1:0], little-endian lanes;
  cpu_ok  out  1  cpu_data valid for the current cpu_addr;
  obj_cs  in  1  object fetch enable (level);
  obj_addr  in  13  object ROM word address;
  objrom_data  out  32  last fetched object word;
  obj_ok  out  1  objrom_data valid for the current obj_addr;
  sdram_req  out  1  read request to the SDRAM controller;
  sdram_addr  out  22  SDRAM word address;
  sdram_ack  in  1  controller accepted the request;
  sdram_rdy  in  1  sdram_dout valid, one-cycle pulse;
  sdram_dout  in  32  read data.

Function
REQ-005 FSM states IDLE, WAIT_ACK, WAIT_RDY; exactly one access in flight.
REQ-006 A requester is pending when its cs is high and its slot is not valid for its current address.
REQ-007 IDLE: if any requester is pending, select a winner, capture its word address, drive sdram_addr = offset + word address, raise sdram_req, go to WAIT_ACK on the same edge.
REQ-008 Priority: object wins unless the CPU is pending and the object has already won MAX_OBJ consecutive grants with the CPU pending, in which case the CPU wins.
REQ-009 Consecutive-grant counter clears on any CPU grant and whenever the CPU is not pending; it saturates at MAX_OBJ.
REQ-010 WAIT_ACK: hold sdram_req and sdram_addr stable; on sdram_ack drop sdram_req the next cycle and go to WAIT_RDY.
REQ-011 WAIT_RDY: on sdram_rdy store sdram_dout and the captured address into the winner's slot, set its valid flag, return to IDLE; a new grant is possible on the following cycle.
REQ-012 sdram_ack and sdram_rdy in the same cycle: treated as ack followed by immediate completion; FSM goes straight to IDLE.
REQ-013 cpu_ok/obj_ok are combinational: cs high AND slot valid AND stored address equals current address; ok rises the cycle after the sdram_rdy pulse.
REQ-014 Address change while in flight: the access completes and is stored under its captured address; ok stays low for the new address; the new address is requested from IDLE.
REQ-015 cs falling while in flight: the access still completes and is stored; no cancellation.
REQ-016 objrom_data and cpu_data hold their last stored value while ok is low.
REQ-017 CPU word address is cpu_addr[14:2]; object word address is obj_addr; additions wrap modulo 2^22.

Reset
REQ-018 While rst_n is low at a clk edge: state IDLE, sdram_req 0, sdram_addr 0, both valid flags 0, grant counter 0, stored data 0, cpu_ok 0, obj_ok 0.
REQ-019 Reset mid-access abandons it; an sdram_rdy arriving after reset release while in IDLE is ignored.

Configuration
REQ-020 Macro JTPOPEYE_CPU_CACHE_EN defined: the CPU slot is a one-word cache; any cpu_addr sharing the stored word address hits with no SDRAM access.
REQ-021 Macro undefined: the CPU slot matches on the full 15-bit byte address; each new byte address, including same-word addresses, issues an SDRAM read.

Structure
REQ-022 Package jtpopeye_pkg holds the FSM state enum, the 22-bit SDRAM address width constant and default offsets.
REQ-023 One sub-module, jtpopeye_sdram_slot, instantiated twice: stored address, data, valid flag and ok compare.

Verification
REQ-024 Obj only: obj_cs=1, obj_addr=13'h0010, ack at +2, rdy at +5 -> sdram_addr=22'h002010, obj_ok high one cycle after rdy, objrom_data=sdram_dout.
REQ-025 Contention: both pending every cycle, MAX_OBJ=2 -> grant order obj, obj, cpu, obj, obj, cpu.
REQ-026 Cache: JTPOPEYE_CPU_CACHE_EN set, cpu_addr 15'h0100 then 15'h0103 -> one SDRAM read; cpu_data = byte lanes 0 then 3; without macro -> two reads.
REQ-027 Address change mid-flight: obj_addr 13'h0005 -> 13'h0006 during WAIT_RDY -> obj_ok stays 0; second request to 22'h002006 issued.
REQ-028 rst_n low during WAIT_RDY, rdy pulse after release -> sdram_req 0, both ok 0, no slot update.
REQ-029 ack and rdy together -> FSM in IDLE next cycle, ok high next cycle.
